// File: rtl/booth_multiplier_pkg.sv
// Shared multdiv definitions: datapath width, FSM states, Booth digit encodings.
// Pulled in by the Booth multiplier and its recoder.
package booth_multiplier_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_t;

    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } booth_digit_t;

    localparam booth_digit_t DIG_ZERO = '{neg: 1'b0, two: 1'b0, zero: 1'b1};
    localparam booth_digit_t DIG_P1   = '{neg: 1'b0, two: 1'b0, zero: 1'b0};
    localparam booth_digit_t DIG_P2   = '{neg: 1'b0, two: 1'b1, zero: 1'b0};
    localparam booth_digit_t DIG_M2   = '{neg: 1'b1, two: 1'b1, zero: 1'b0};
    localparam booth_digit_t DIG_M1   = '{neg: 1'b1, two: 1'b0, zero: 1'b0};

endpackage

// File: rtl/booth_multiplier_recoder.sv
// Radix-4 modified Booth recoder: multiplier bit triplet -> signed digit.
// Purely combinational.
module booth_recoder
    import booth_multiplier_pkg::*;
(
    input  logic [2:0]   triplet,
    output booth_digit_t digit
);

    always_comb begin
        digit = DIG_ZERO;
        unique case (triplet)
            3'b000, 3'b111: digit = DIG_ZERO;
            3'b001, 3'b010: digit = DIG_P1;
            3'b011:         digit = DIG_P2;
            3'b100:         digit = DIG_M2;
            3'b101, 3'b110: digit = DIG_M1;
        endcase
    end

endmodule

// File: rtl/booth_multiplier.sv
// Iterative signed radix-4 Booth multiplier, two multiplier bits per cycle.
// Start with ctrl_MULT; product/overflow valid on the one-cycle result_rdy pulse.
module booth_multiplier
    import booth_multiplier_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
)
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] product,
    output logic             overflow,
    output logic             result_rdy,
    output logic             busy
);

    localparam int ITERS = WIDTH / 2;
    localparam int AW    = WIDTH + 2;
    localparam int PW    = 2 * WIDTH + 3;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    md_state_t     state;
    logic [CW-1:0] count;
    logic [AW-1:0] a_q;
    logic [PW-1:0] p_q;

    booth_digit_t       digit;
    alu_op_t            op;
    logic [AW-1:0]      acc;
    logic [AW-1:0]      addend;
    logic [AW-1:0]      sum;
    logic [PW-1:0]      p_shift;
    logic [2*WIDTH-1:0] full;
    logic [WIDTH:0]     hi;
    logic               ovf;

    booth_recoder u_rec (
        .triplet (p_q[2:0]),
        .digit   (digit)
    );

    // A is held in WIDTH+2 bits so 2A of the most negative operand cannot wrap
    always_comb begin
        acc    = p_q[PW-1 -: AW];
        op     = digit.neg ? ALU_SUB : ALU_ADD;
        addend = '0;
        if (!digit.zero) begin
            addend = digit.two ? {a_q[AW-2:0], 1'b0} : a_q;
        end
        sum     = (op == ALU_SUB) ? (acc - addend) : (acc + addend);
        p_shift = {{2{sum[AW-1]}}, sum, p_q[WIDTH:2]};
    end

    assign full = p_q[2*WIDTH:1];
    assign hi   = full[2*WIDTH-1:WIDTH-1];
    assign ovf  = ~((&hi) | ~(|hi));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            a_q        <= '0;
            p_q        <= '0;
            product    <= '0;
            overflow   <= 1'b0;
            result_rdy <= 1'b0;
            busy       <= 1'b0;
        end else begin
            result_rdy <= 1'b0;
            if (ctrl_MULT) begin
                // a new start always wins, aborting anything in flight
                state <= ST_RUN;
                count <= '0;
                a_q   <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
                p_q   <= {{AW{1'b0}}, multiplier, 1'b0};
                busy  <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        busy <= 1'b0;
                    end
                    ST_RUN: begin
                        p_q   <= p_shift;
                        count <= count + CW'(1);
                        if (count == LAST) begin
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        product    <= full[WIDTH-1:0];
                        overflow   <= ovf;
                        result_rdy <= 1'b1;
                        state      <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed and random bench for booth_multiplier with a result scoreboard.
// Expected products come from constants or a 64-bit signed reference model.
module tb_booth_multiplier;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic [31:0] product;
    logic        overflow;
    logic        result_rdy;
    logic        busy;

    booth_multiplier dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ctrl_MULT    (ctrl_MULT),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .overflow     (overflow),
        .result_rdy   (result_rdy),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] p;
        logic        o;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb_v;
        logic signed [63:0] f;
        exp_t r;
        sa   = $signed(a);
        sb_v = $signed(b);
        f    = sa * sb_v;
        r.p  = f[31:0];
        r.o  = ~((&f[63:31]) | ~(|f[63:31]));
        return r;
    endfunction

    // drive a one-cycle start; returns at the negedge after the load edge
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT    = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clock);
        #1;
        check("busy after load", busy, 1);
        @(negedge clock);
        ctrl_MULT    = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic await_rdy(input int limit, output int edges, output logic seen);
        seen  = 1'b0;
        edges = 0;
        while (!seen && edges < limit) begin
            @(posedge clock);
            #1;
            edges++;
            if (result_rdy) seen = 1'b1;
        end
    endtask

    task automatic finish_op(input string tag, input int exp_lat);
        int   e;
        logic s;
        exp_t x;
        await_rdy(40, e, s);
        check({tag, " rdy seen"}, s, 1);
        if (s && sb.size() > 0) begin
            x = sb.pop_front();
            check({tag, " product"}, product, x.p);
            check({tag, " overflow"}, overflow, x.o);
            check({tag, " busy in rdy"}, busy, 1);
            if (exp_lat > 0) check({tag, " latency"}, e, exp_lat);
            @(posedge clock);
            #1;
            check({tag, " rdy width"}, result_rdy, 0);
            check({tag, " busy after"}, busy, 0);
        end else if (sb.size() > 0) begin
            void'(sb.pop_front());
        end
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic o, input int lat);
        sb.push_back('{p: p, o: o});
        launch(a, b);
        finish_op(tag, lat);
    endtask

    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFFFFFF,
                                 32'h80000000, 32'h7FFFFFFF, 32'h0000FFFF};

    initial begin
        int          pulses;
        int          first;
        logic [31:0] ra;
        logic [31:0] rb;
        exp_t        m;

        #1;
        check("reset outputs", {product, overflow, result_rdy, busy}, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("idle outputs", {product, overflow, result_rdy, busy}, 0);

        op("3*4", 32'd3, 32'd4, 32'h0000000C, 1'b0, 17);
        repeat (3) @(posedge clock);
        #1;
        check("3*4 product held", product, 32'h0000000C);

        op("-7*6", 32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0, 17);
        op("0*min", 32'd0, 32'h80000000, 32'h0, 1'b0, 17);
        op("max*2", 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, 17);
        op("min*-1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 17);
        op("ffff^2", 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b1, 17);
        op("8000*-10000", 32'h00008000, 32'hFFFF0000, 32'h80000000, 1'b0, 17);
        op("min*min", 32'h80000000, 32'h80000000, 32'h0, 1'b1, 17);
        op("min*2", 32'h80000000, 32'd2, 32'h0, 1'b1, 17);

        // abort: 5*5 restarted with 9*9 on edge 8
        sb.push_back('{p: 32'd81, o: 1'b0});
        @(negedge clock);
        ctrl_MULT    = 1'b1;
        multiplicand = 32'd5;
        multiplier   = 32'd5;
        @(posedge clock);
        #1;
        pulses = 0;
        first  = -1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clock);
            if (k == 8) begin
                ctrl_MULT    = 1'b1;
                multiplicand = 32'd9;
                multiplier   = 32'd9;
            end else begin
                ctrl_MULT = 1'b0;
            end
            @(posedge clock);
            #1;
            if (result_rdy) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        check("abort pulses", pulses, 1);
        check("abort rdy edge", first, 25);
        m = sb.pop_front();
        check("abort product", product, m.p);

        // ctrl_MULT held for three edges; the last operands win
        sb.push_back('{p: 32'hFFFFFFDD, o: 1'b0});
        @(negedge clock);
        ctrl_MULT    = 1'b1;
        multiplicand = 32'd1;
        multiplier   = 32'd1;
        @(negedge clock);
        multiplicand = 32'd2;
        multiplier   = 32'd3;
        @(negedge clock);
        multiplicand = 32'hFFFFFFFB;
        multiplier   = 32'd7;
        @(posedge clock);
        #1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        finish_op("held", 17);

        // asynchronous reset in the middle of an operation
        launch(32'd7, 32'd3);
        repeat (10) @(posedge clock);
        #2;
        check("busy before reset", busy, 1);
        reset_n = 1'b0;
        #1;
        check("midop reset outputs", {product, overflow, result_rdy, busy}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (result_rdy) pulses++;
        end
        check("no rdy after reset", pulses, 0);
        op("12*-12", 32'd12, 32'hFFFFFFF4, 32'hFFFFFF70, 1'b0, 17);

        for (int i = 0; i < 1000; i++) begin
            ra = ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : $urandom;
            rb = ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : $urandom;
            m  = model(ra, rb);
            op("random", ra, rb, m.p, m.o, 17);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
